// File: rtl/bcd_cnt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_ctrl_if
// Description : Button / counter-control bundle between the board buttons,
//               the bcd_cnt_ctrl sequencer and the BCD counter datapath.
//               slave  = sequencer side (buttons in, strobes out)
//               master = board/counter side
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_cnt_ctrl_if;
  logic       Toggle;   // raw button, active-low, asynchronous
  logic       Push;     // raw button, active-low, asynchronous
  logic       Cnt_en;   // one-cycle count strobe
  logic       Cnt_dir;  // 1 = up, 0 = down
  logic       Cnt_clr;  // one-cycle clear strobe
  logic [1:0] State_o;  // sequencer state for debug LEDs

  modport master (
    output Toggle,
    output Push,
    input  Cnt_en,
    input  Cnt_dir,
    input  Cnt_clr,
    input  State_o
  );

  modport slave (
    input  Toggle,
    input  Push,
    output Cnt_en,
    output Cnt_dir,
    output Cnt_clr,
    output State_o
  );
endinterface
`default_nettype wire

// File: rtl/bcd_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_ctrl
// Description : Control sequencer for the 3-digit BCD up/down counter.
//               Synchronizes and debounces the active-low Toggle and Push
//               buttons, detects press/release, and drives the registered
//               count-enable, direction and clear strobes.
//               Optional macro AUTO_RPT_EN enables auto-repeat while Push
//               stays held (RPT_WAIT / RPT states); without it each press
//               yields exactly one count strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_cnt_ctrl #(
  parameter int DB_CYCLES = 4,   // stable samples before a debounced change
  parameter int RPT_DLY   = 16,  // first pulse -> first repeat pulse
  parameter int RPT_PER   = 4    // spacing of subsequent repeat pulses
) (
  input  logic          Clk,
  input  logic          Rst,
  bcd_cnt_ctrl_if.slave bus
);

  localparam int c_max_par = (DB_CYCLES > RPT_DLY) ?
                             ((DB_CYCLES > RPT_PER) ? DB_CYCLES : RPT_PER) :
                             ((RPT_DLY   > RPT_PER) ? RPT_DLY   : RPT_PER);
  localparam int c_cnt_w = $clog2(c_max_par) + 1;

  localparam logic [c_cnt_w-1:0] c_db_last  = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_dly_last = c_cnt_w'(RPT_DLY - 1);
  localparam logic [c_cnt_w-1:0] c_per_last = c_cnt_w'(RPT_PER - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = '1;

  localparam int c_push = 0;
  localparam int c_tgl  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    RPT_WAIT = 2'd2,
    RPT      = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_push_deb;
  logic       w_push_rel;

  assign w_raw = {bus.Toggle, bus.Push};

  // --------------------------------------------------------------------------
  // Per-button conditioning: 2-FF synchronizer, debouncer, edge detector.
  // After reset a button is "unarmed": the debouncer then only counts
  // consecutive released samples, and the button arms once it has been seen
  // released for DB_CYCLES samples. A button held through reset therefore
  // produces no press until it is released and pressed again.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic               r_sync1;
      logic               r_sync2;
      logic               r_deb;
      logic               r_deb_q;
      logic               r_arm;
      logic [c_cnt_w-1:0] r_db_cnt;

      // Synchronize, debounce and keep the previous debounced level.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          r_sync1  <= 1'b1;
          r_sync2  <= 1'b1;
          r_deb    <= 1'b1;
          r_deb_q  <= 1'b1;
          r_arm    <= 1'b0;
          r_db_cnt <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_deb_q <= r_deb;
          if (!r_arm) begin
            if (!r_sync2) begin
              r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
              r_arm    <= 1'b1;
              r_db_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + 1'b1;
            end
          end else if (r_sync2 == r_deb) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_db_last) begin
            r_deb    <= r_sync2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_deb_q & ~r_deb;

      if (gi == c_push) begin : g_push_taps
        assign w_push_deb = r_deb;
        assign w_push_rel = ~r_deb_q & r_deb;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nx;
  logic               r_en;
  logic               w_en_nx;
  logic               r_clr;
  logic               w_clr_nx;
  logic               r_dir;
  logic               w_dir_nx;
  logic               r_clr_pend;  // clear owed after a simultaneous press
  logic               w_clr_pend_nx;
  logic [c_cnt_w-1:0] r_rpt_cnt;   // cycles since the last count pulse
  logic [c_cnt_w-1:0] w_rpt_nx;

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_clr      <= 1'b0;
      r_dir      <= 1'b1;
      r_clr_pend <= 1'b0;
      r_rpt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_en       <= w_en_nx;
      r_clr      <= w_clr_nx;
      r_dir      <= w_dir_nx;
      r_clr_pend <= w_clr_pend_nx;
      r_rpt_cnt  <= w_rpt_nx;
    end
  end

  // Next state and next outputs. A Toggle press while Push is held means
  // "clear"; when both presses land together the count pulse goes first and
  // the clear follows one cycle later so the strobes never overlap.
  always_comb begin
    w_state_nx    = r_state;
    w_en_nx       = 1'b0;
    w_clr_nx      = 1'b0;
    w_dir_nx      = r_dir;
    w_clr_pend_nx = 1'b0;
    w_rpt_nx      = (r_rpt_cnt == c_cnt_full) ? r_rpt_cnt : r_rpt_cnt + 1'b1;

    if (r_clr_pend) begin
      w_clr_nx   = 1'b1;
      w_state_nx = IDLE;
    end else if (w_press[c_tgl] && !w_push_deb) begin
      if (w_press[c_push]) begin
        w_en_nx       = 1'b1;
        w_state_nx    = HELD;
        w_clr_pend_nx = 1'b1;
        w_rpt_nx      = '0;
      end else begin
        w_clr_nx   = 1'b1;
        w_state_nx = IDLE;
      end
    end else begin
      if (w_press[c_tgl]) begin
        w_dir_nx = ~r_dir;
      end
      case (r_state)
        IDLE: begin
          if (w_press[c_push]) begin
            w_en_nx    = 1'b1;
            w_state_nx = HELD;
            w_rpt_nx   = '0;
          end
        end
        HELD: begin
          if (w_push_rel) begin
            w_state_nx = IDLE;
          end else begin
`ifdef AUTO_RPT_EN
            w_state_nx = RPT_WAIT;
            w_rpt_nx   = c_cnt_w'(1);
`else
            w_state_nx = HELD;
`endif
          end
        end
        RPT_WAIT: begin
          if (w_push_rel) begin
            w_state_nx = IDLE;
          end else if (r_rpt_cnt == c_dly_last) begin
            w_state_nx = RPT;
            w_en_nx    = 1'b1;
            w_rpt_nx   = '0;
          end
        end
        RPT: begin
          if (w_push_rel) begin
            w_state_nx = IDLE;
          end else if (r_rpt_cnt == c_per_last) begin
            w_en_nx  = 1'b1;
            w_rpt_nx = '0;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign bus.Cnt_en  = r_en;
  assign bus.Cnt_clr = r_clr;
  assign bus.Cnt_dir = r_dir;
  assign bus.State_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bcd_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_cnt_ctrl
// Description : Self-checking bench for bcd_cnt_ctrl. Expected strobe cycles
//               are queued when stimulus is driven and popped as the strobes
//               appear. Build with AUTO_RPT_EN to select auto-repeat
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_cnt_ctrl;

  localparam int DB  = 4;
  localparam int DLY = 16;
  localparam int PER = 4;
  localparam int LAT = DB + 3;  // drive edge -> Cnt_en edge

  logic Clk = 1'b0;
  logic Rst;

  bcd_cnt_ctrl_if u_if ();

  bcd_cnt_ctrl #(
    .DB_CYCLES (DB),
    .RPT_DLY   (DLY),
    .RPT_PER   (PER)
  ) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (u_if)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int push_len;
    int tgl_len;
    bit exp_en;
    bit exp_clr;
    bit exp_flip;
  } vec_t;

  vec_t vecs [11];
  int   cyc        = 0;
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   n_en_seen  = 0;
  int   n_clr_seen = 0;
  int   exp_en_q  [$];
  int   exp_clr_q [$];
  logic exp_dir;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare this cycle's strobes against the scoreboard.
  task automatic scan();
    while (exp_en_q.size() > 0 && exp_en_q[0] < cyc)
      chk("en_missed", -1, exp_en_q.pop_front());
    while (exp_clr_q.size() > 0 && exp_clr_q[0] < cyc)
      chk("clr_missed", -1, exp_clr_q.pop_front());
    if (u_if.Cnt_en) begin
      n_en_seen++;
      if (exp_en_q.size() == 0) chk("en_unexpected", cyc, -1);
      else                      chk("en_cycle", cyc, exp_en_q.pop_front());
      chk("en_clr_overlap", int'(u_if.Cnt_clr), 0);
    end
    if (u_if.Cnt_clr) begin
      n_clr_seen++;
      if (exp_clr_q.size() == 0) chk("clr_unexpected", cyc, -1);
      else                       chk("clr_cycle", cyc, exp_clr_q.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      cyc++;
      scan();
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    int len;
    k   = cyc;
    len = (v.push_len > v.tgl_len) ? v.push_len : v.tgl_len;
    if (v.exp_en)   exp_en_q.push_back(k + LAT);
    if (v.exp_clr)  exp_clr_q.push_back(k + LAT + 1);
    if (v.exp_flip) exp_dir = ~exp_dir;
    for (int c = 0; c < len; c++) begin
      u_if.Push   = (c < v.push_len) ? 1'b0 : 1'b1;
      u_if.Toggle = (c < v.tgl_len)  ? 1'b0 : 1'b1;
      tick(1);
    end
    u_if.Push   = 1'b1;
    u_if.Toggle = 1'b1;
    tick(20);
    chk($sformatf("vec%0d_dir", idx), int'(u_if.Cnt_dir), int'(exp_dir));
    chk($sformatf("vec%0d_state", idx), int'(u_if.State_o), 0);
    chk($sformatf("vec%0d_en_pending", idx), exp_en_q.size(), 0);
    chk($sformatf("vec%0d_clr_pending", idx), exp_clr_q.size(), 0);
  endtask

  initial begin
    int   k;
    int   s0;
    int   s1;
    vec_t tgl_only;

    //            push tgl  en    clr   flip
    vecs[0]  = '{10,  0,  1'b1, 1'b0, 1'b0};  // plain press
    vecs[1]  = '{0,   10, 1'b0, 1'b0, 1'b1};  // toggle -> down
    vecs[2]  = '{0,   10, 1'b0, 1'b0, 1'b1};  // toggle -> up
    vecs[3]  = '{0,   10, 1'b0, 1'b0, 1'b1};  // toggle -> down
    vecs[4]  = '{3,   0,  1'b0, 1'b0, 1'b0};  // one sample short of debounce
    vecs[5]  = '{4,   0,  1'b1, 1'b0, 1'b0};  // exactly DB samples
    vecs[6]  = '{0,   3,  1'b0, 1'b0, 1'b0};  // short toggle ignored
    vecs[7]  = '{0,   4,  1'b0, 1'b0, 1'b1};  // minimal toggle -> up
    vecs[8]  = '{10,  10, 1'b1, 1'b1, 1'b0};  // simultaneous presses
    vecs[9]  = '{16,  0,  1'b1, 1'b0, 1'b0};  // release lands on first repeat slot
    vecs[10] = '{1,   0,  1'b0, 1'b0, 1'b0};  // single-sample glitch
    tgl_only = '{0,   10, 1'b0, 1'b0, 1'b1};

    Rst         = 1'b1;
    u_if.Push   = 1'b1;
    u_if.Toggle = 1'b1;
    exp_dir     = 1'b1;
    tick(3);
    chk("rst_en",    int'(u_if.Cnt_en),  0);
    chk("rst_clr",   int'(u_if.Cnt_clr), 0);
    chk("rst_dir",   int'(u_if.Cnt_dir), 1);
    chk("rst_state", int'(u_if.State_o), 0);
    Rst = 1'b0;
    tick(10);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Repeated short glitches: no strobes at all.
    s0 = n_en_seen;
    s1 = n_clr_seen;
    for (int g = 0; g < 5; g++) begin
      u_if.Push = 1'b0;
      tick(3);
      u_if.Push = 1'b1;
      tick(10);
    end
    tick(10);
    chk("glitch_en_count",  n_en_seen - s0, 0);
    chk("glitch_clr_count", n_clr_seen - s1, 0);

    // Long hold: first pulse at t, repeats at t+16, t+20 .. t+32.
    k = cyc;
    u_if.Push = 1'b0;
    exp_en_q.push_back(k + LAT);
`ifdef AUTO_RPT_EN
    exp_en_q.push_back(k + LAT + DLY);
    for (int r = 1; r <= 4; r++) exp_en_q.push_back(k + LAT + DLY + r * PER);
`endif
    tick(LAT);
    chk("hold_state_t", int'(u_if.State_o), 1);
    tick(1);
`ifdef AUTO_RPT_EN
    chk("hold_state_t1", int'(u_if.State_o), 2);
`else
    chk("hold_state_t1", int'(u_if.State_o), 1);
`endif
    tick(DLY - 1);
`ifdef AUTO_RPT_EN
    chk("hold_state_t16", int'(u_if.State_o), 3);
`else
    chk("hold_state_t16", int'(u_if.State_o), 1);
`endif
    tick(36 - LAT - DLY);
    u_if.Push = 1'b1;
    tick(20);
    chk("hold_state_end", int'(u_if.State_o), 0);
    chk("hold_en_pending", exp_en_q.size(), 0);

    // Push held, Toggle pressed: one clear, no direction change, no more
    // counts until Push is released and pressed again.
    k = cyc;
    u_if.Push = 1'b0;
    exp_en_q.push_back(k + LAT);
    tick(10);
    u_if.Toggle = 1'b0;
    exp_clr_q.push_back(k + 10 + LAT);
    tick(LAT + 1);
    chk("clr_state", int'(u_if.State_o), 0);
    chk("clr_dir", int'(u_if.Cnt_dir), int'(exp_dir));
    tick(2);
    u_if.Toggle = 1'b1;
    tick(20);
    u_if.Push = 1'b1;
    tick(20);
    chk("clr_dir_after", int'(u_if.Cnt_dir), int'(exp_dir));
    chk("clr_pending", exp_clr_q.size(), 0);
    k = cyc;
    u_if.Push = 1'b0;
    exp_en_q.push_back(k + LAT);
    tick(10);
    u_if.Push = 1'b1;
    tick(20);
    chk("repress_en_pending", exp_en_q.size(), 0);

    // Leave direction at down so reset visibly restores it.
    run_vec(99, tgl_only);

    // Reset during the repeat phase with Push still held.
    k = cyc;
    u_if.Push = 1'b0;
    exp_en_q.push_back(k + LAT);
`ifdef AUTO_RPT_EN
    exp_en_q.push_back(k + LAT + DLY);
    exp_en_q.push_back(k + LAT + DLY + PER);
`endif
    tick(LAT + DLY + PER + 2);
    Rst = 1'b1;
    tick(1);
    chk("midrst_en",    int'(u_if.Cnt_en),  0);
    chk("midrst_clr",   int'(u_if.Cnt_clr), 0);
    chk("midrst_dir",   int'(u_if.Cnt_dir), 1);
    chk("midrst_state", int'(u_if.State_o), 0);
    exp_dir = 1'b1;
    tick(2);
    Rst = 1'b0;
    s0 = n_en_seen;
    tick(30);
    chk("held_after_rst_en", n_en_seen - s0, 0);
    u_if.Push = 1'b1;
    tick(15);
    k = cyc;
    u_if.Push = 1'b0;
    exp_en_q.push_back(k + LAT);
    tick(10);
    u_if.Push = 1'b1;
    tick(20);
    chk("post_rst_en_pending", exp_en_q.size(), 0);
    chk("post_rst_state", int'(u_if.State_o), 0);
    chk("post_rst_dir", int'(u_if.Cnt_dir), int'(exp_dir));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
